// File: rtl/vga_render.sv
// VGA timing generator and pixel colouriser: divides clk_100mhz down to the pixel rate,
// produces sync/blanking and maps the game-loop pixel category to an RGB444 colour.
module vga_render #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned H_VISIBLE    = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_VISIBLE    = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter logic [11:0] COLOR_NONE   = 12'h000,
    parameter logic [11:0] COLOR_WALL   = 12'h888,
    parameter logic [11:0] COLOR_TANK   = 12'h0F0,
    parameter logic [11:0] COLOR_BULLET = 12'hF00,
    parameter logic [11:0] COLOR_OTHER  = 12'hF0F
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic [3:0]  category,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        video_on,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int unsigned PH_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START  = H_VISIBLE + H_FP;
    localparam int unsigned HS_END    = H_VISIBLE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_START  = V_VISIBLE + V_FP;
    localparam int unsigned VS_END    = V_VISIBLE + V_FP + V_SYNC - 1;
    // Outputs are sampled mid-pixel so category (1 clk behind the counters) has settled.
    localparam int unsigned SAMPLE_PH = (CLK_DIV > 2) ? 2 : CLK_DIV - 1;

    logic [PH_W-1:0] ph_q, ph_d;
    logic [9:0]      h_cnt_q, h_cnt_d;
    logic [9:0]      v_cnt_q, v_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            frame_tick_q, frame_tick_d;
    logic [11:0]     rgb_q, rgb_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            video_on_q, video_on_d;

    logic            ph_end, h_end, v_end, visible;
    logic [11:0]     color;

    // Pixel phase, raster counters and frame bookkeeping.
    always_comb begin
        ph_d         = ph_q + PH_W'(1);
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        frame_tick_d = 1'b0;

        ph_end = (ph_q >= PH_W'(CLK_DIV - 1));
        h_end  = (h_cnt_q >= 10'(H_TOTAL - 1));
        v_end  = (v_cnt_q >= 10'(V_TOTAL - 1));

        if (ph_end) begin
            ph_d = '0;
            if (h_end) begin
                h_cnt_d = '0;
                if (v_end) begin
                    v_cnt_d      = '0;
                    frame_tick_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Colour and sync decode, captured once per pixel at the sample phase.
    always_comb begin
        rgb_d      = rgb_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        video_on_d = video_on_q;

        visible = (h_cnt_q < 10'(H_VISIBLE)) && (v_cnt_q < 10'(V_VISIBLE));

        case (category)
            4'd0:    color = COLOR_NONE;
            4'd1:    color = COLOR_WALL;
            4'd2:    color = COLOR_TANK;
            4'd3:    color = COLOR_BULLET;
            default: color = COLOR_OTHER;
        endcase

        if (ph_q == PH_W'(SAMPLE_PH)) begin
            rgb_d      = visible ? color : 12'h000;
            video_on_d = visible;
            hs_d       = !((h_cnt_q >= 10'(HS_START)) && (h_cnt_q <= 10'(HS_END)));
            vs_d       = !((v_cnt_q >= 10'(VS_START)) && (v_cnt_q <= 10'(VS_END)));
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            ph_q         <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
            rgb_q        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            video_on_q   <= 1'b0;
        end else begin
            ph_q         <= ph_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            video_on_q   <= video_on_d;
        end
    end

    assign pixel_x    = h_cnt_q;
    assign pixel_y    = v_cnt_q;
    assign vga_r      = rgb_q[11:8];
    assign vga_g      = rgb_q[7:4];
    assign vga_b      = rgb_q[3:0];
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/vga_render.md
VGA_RENDER -- requirements
Module: vga_render

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CLK_DIV, 4: clk_100mhz cycles per pixel (25 MHz pixel rate).
- H_VISIBLE/H_FP/H_SYNC/H_BP, 640/16/96/48: horizontal timing in pixels (total 800).
- V_VISIBLE/V_FP/V_SYNC/V_BP, 480/10/2/33: vertical timing in lines (total 525).
- COLOR_NONE/COLOR_WALL/COLOR_TANK/COLOR_BULLET/COLOR_OTHER, 12'h000/12'h888/12'h0F0/12'hF00/12'hF0F: RGB444 colour per category.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_100mhz, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- category, in, 4: pixel class from the game loop (0 NONE, 1 WALL, 2 TANK, 3 BULLET); registered there, valid 1 clk after pixel_x/pixel_y change.
- pixel_x, out, 10: current horizontal counter, 0..799.
- pixel_y, out, 10: current vertical counter, 0..524.
- vga_r, vga_g, vga_b, out, 4 each: colour outputs.
- vga_hs, vga_vs, out, 1 each: syncs, active-low.
- video_on, out, 1: high while the emitted pixel is visible.
- frame_tick, out, 1: one-clock pulse at frame start.
- frame_cnt, out, 16: frames completed, wraps 65535->0.

Function
REQ-003 Phase counter ph SHALL count 0..CLK_DIV-1 every clock and wrap to 0.
REQ-004 On the edge where ph==CLK_DIV-1, h_cnt SHALL increment; at 799 it SHALL wrap to 0 and v_cnt SHALL increment; at v_cnt 524 with h_cnt wrap, v_cnt SHALL wrap to 0.
REQ-005 pixel_x/pixel_y SHALL be driven directly from the h_cnt/v_cnt registers, each value held for exactly CLK_DIV clocks.
REQ-006 On the edge where ph==2, the block SHALL register vga_r/g/b, vga_hs, vga_vs and video_on from the current h_cnt, v_cnt and category; outputs change only on that edge (2-clock latency from counter update, uniform for colour and sync).
REQ-007 Visible region: h_cnt<640 and v_cnt<480; outside it RGB SHALL be 0 and video_on 0 regardless of category.
REQ-008 Colour map inside the visible region: 0->COLOR_NONE, 1->COLOR_WALL, 2->COLOR_TANK, 3->COLOR_BULLET, 4..15->COLOR_OTHER; bits [11:8] R, [7:4] G, [3:0] B.
REQ-009 vga_hs SHALL be 0 for h_cnt 656..751 inclusive, else 1; vga_vs SHALL be 0 for v_cnt 490..491 inclusive, else 1.
REQ-010 frame_tick SHALL pulse high for exactly one clock on the edge where h_cnt and v_cnt both wrap to 0; frame_cnt SHALL increment on the same edge.
REQ-011 Widths: counters 10 bits; comparisons unsigned; no counter SHALL exceed its terminal value.
REQ-012 category is sampled only at ph==2; changes at other phases SHALL have no effect.

Reset
REQ-013 While rst is high at a clock edge: ph, h_cnt, v_cnt, frame_cnt <= 0; RGB <= 0; vga_hs, vga_vs <= 1; video_on, frame_tick <= 0.
REQ-014 Reset asserted mid-frame SHALL restart timing at pixel (0,0), ph 0, on the first edge after rst deasserts, without emitting frame_tick.
REQ-015 Reset release SHALL NOT itself produce a frame_tick; the first pulse occurs after one full frame.

Verification
REQ-016 After reset release, count clocks between frame_tick pulses -> exactly 800*525*4 = 1,680,000.
REQ-017 Monitor vga_hs over one line -> low for 96*4 = 384 clocks, period 3200 clocks; vga_vs low for 2 lines = 6400 clocks per frame.
REQ-018 Hold category=2 -> RGB=0/F/0 only while video_on; RGB=0 at pixel_x=640 and at pixel_y=480.
REQ-019 Model category as a 1-clock-registered function of pixel_x (category = pixel_x[1:0]) -> output colour at x=1 is WALL 8/8/8, x=3 BULLET F/0/0; category=7 -> F/0/F.
REQ-020 Assert rst for 1 clock at pixel (300,200) -> next clock pixel_x=0, pixel_y=0, vga_hs=vga_vs=1, no frame_tick, frame_cnt=0.
REQ-021 Run 65536 frames (or force frame_cnt=65535) -> wraps to 0 on the next frame_tick.
